// File: rtl/conv2d_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_seq_ctrl_if
// Description : Bundles the start/done control, feature/weight SRAM read
//               ports, conv2d_core operand/result and output stream of the
//               conv2d sequencer. The master modport is the sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv2d_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    // layer-scheduler control
    logic                               start;
    logic                               busy;
    logic                               done;
    // feature-map SRAM read port
    logic                               fm_rd_en;
    logic [ADDR_WIDTH-1:0]              fm_rd_addr;
    logic [DATA_WIDTH-1:0]              fm_rd_data;
    // weight SRAM read port
    logic                               wt_rd_en;
    logic [ADDR_WIDTH-1:0]              wt_rd_addr;
    logic [DATA_WIDTH-1:0]              wt_rd_data;
    // conv2d_core operands and result
    logic [0:8][DATA_WIDTH-1:0]         core_window;
    logic [0:8][DATA_WIDTH-1:0]         core_weights;
    logic signed [2*DATA_WIDTH-1:0]     core_result;
    // result stream
    logic                               out_valid;
    logic                               out_ready;
    logic signed [2*DATA_WIDTH-1:0]     out_data;
    logic [ADDR_WIDTH-1:0]              out_addr;

    modport master (
        input  start,
        output busy,
        output done,
        output fm_rd_en,
        output fm_rd_addr,
        input  fm_rd_data,
        output wt_rd_en,
        output wt_rd_addr,
        input  wt_rd_data,
        output core_window,
        output core_weights,
        input  core_result,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_addr
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  fm_rd_en,
        input  fm_rd_addr,
        output fm_rd_data,
        input  wt_rd_en,
        input  wt_rd_addr,
        output wt_rd_data,
        input  core_window,
        input  core_weights,
        output core_result,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_addr
    );
endinterface
`default_nettype wire

// File: rtl/conv2d_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_seq_ctrl
// Description : Walks one conv2d_core over an IMG_H x IMG_W feature map
//               (3x3 kernel, stride 1, valid padding). Loads the nine
//               weights once, then for each output position fetches the
//               3x3 window, lets the core register its sum and streams the
//               result out with its row-major output address.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  wire              clk,
    input  wire              rst,
    conv2d_seq_ctrl_if.master bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD_W = 3'd1;
    localparam logic [2:0] c_ST_FETCH  = 3'd2;
    localparam logic [2:0] c_ST_CONV   = 3'd3;
    localparam logic [2:0] c_ST_WRITE  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_IMG_W    = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] c_OUT_W    = ADDR_WIDTH'(IMG_W - 2);
    localparam logic [ADDR_WIDTH-1:0] c_OUT_H    = ADDR_WIDTH'(IMG_H - 2);
    // jump from the last pixel of one window row to the first of the next
    localparam logic [ADDR_WIDTH-1:0] c_ROW_STEP = ADDR_WIDTH'(IMG_W - 2);

    logic [2:0]                 r_state;
    logic [3:0]                 r_cnt;     // cycle index inside LOAD_W / FETCH
    logic [1:0]                 r_kcol;    // column of the window pixel being issued
    logic [ADDR_WIDTH-1:0]      r_ox;
    logic [ADDR_WIDTH-1:0]      r_oy;
    logic                       r_fm_rd_en;
    logic [ADDR_WIDTH-1:0]      r_fm_rd_addr;
    logic                       r_wt_rd_en;
    logic [ADDR_WIDTH-1:0]      r_wt_rd_addr;
    logic [0:8][DATA_WIDTH-1:0] r_window;
    logic [0:8][DATA_WIDTH-1:0] r_weights;
    logic [ADDR_WIDTH-1:0]      r_out_addr;

    logic                       w_ox_wrap;
    logic                       w_last;
    logic [ADDR_WIDTH-1:0]      w_next_ox;
    logic [ADDR_WIDTH-1:0]      w_next_oy;
    logic [ADDR_WIDTH-1:0]      w_next_base;

    // position that follows the current one and its top-left pixel address
    always_comb begin
        w_ox_wrap   = (r_ox == c_OUT_W - 1'b1);
        w_last      = w_ox_wrap && (r_oy == c_OUT_H - 1'b1);
        w_next_ox   = w_ox_wrap ? '0 : r_ox + 1'b1;
        w_next_oy   = w_ox_wrap ? r_oy + 1'b1 : r_oy;
        w_next_base = w_next_oy * c_IMG_W + w_next_ox;
    end

    // sequencer FSM with registered strobes, addresses and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_kcol       <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
            r_fm_rd_en   <= 1'b0;
            r_fm_rd_addr <= '0;
            r_wt_rd_en   <= 1'b0;
            r_wt_rd_addr <= '0;
            r_window     <= '0;
            r_weights    <= '0;
            r_out_addr   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_state      <= c_ST_LOAD_W;
                        r_ox         <= '0;
                        r_oy         <= '0;
                        r_cnt        <= '0;
                        r_wt_rd_en   <= 1'b1;
                        r_wt_rd_addr <= '0;
                    end
                end

                c_ST_LOAD_W: begin
                    // data requested in cycle k-1 arrives in cycle k
                    if (r_cnt != 4'd0) begin
                        r_weights[r_cnt - 4'd1] <= bus.wt_rd_data;
                    end
                    if (r_cnt < 4'd8) begin
                        r_wt_rd_en   <= 1'b1;
                        r_wt_rd_addr <= r_wt_rd_addr + 1'b1;
                    end else begin
                        r_wt_rd_en   <= 1'b0;
                    end
                    if (r_cnt == 4'd9) begin
                        r_state      <= c_ST_FETCH;
                        r_cnt        <= '0;
                        r_kcol       <= '0;
                        r_fm_rd_en   <= 1'b1;
                        r_fm_rd_addr <= '0;   // first window is at (0,0)
                    end else begin
                        r_cnt        <= r_cnt + 4'd1;
                    end
                end

                c_ST_FETCH: begin
                    if (r_cnt != 4'd0) begin
                        r_window[r_cnt - 4'd1] <= bus.fm_rd_data;
                    end
                    if (r_cnt < 4'd8) begin
                        r_fm_rd_en <= 1'b1;
                        if (r_kcol == 2'd2) begin
                            r_fm_rd_addr <= r_fm_rd_addr + c_ROW_STEP;
                            r_kcol       <= 2'd0;
                        end else begin
                            r_fm_rd_addr <= r_fm_rd_addr + 1'b1;
                            r_kcol       <= r_kcol + 2'd1;
                        end
                    end else begin
                        r_fm_rd_en <= 1'b0;
                    end
                    if (r_cnt == 4'd9) begin
                        r_state <= c_ST_CONV;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end

                c_ST_CONV: begin
                    // the core registers its sum this cycle
                    r_state    <= c_ST_WRITE;
                    r_out_addr <= r_oy * c_OUT_W + r_ox;
                end

                c_ST_WRITE: begin
                    if (bus.out_ready) begin
                        r_ox <= w_next_ox;
                        r_oy <= w_next_oy;
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_state      <= c_ST_FETCH;
                            r_cnt        <= '0;
                            r_kcol       <= '0;
                            r_fm_rd_en   <= 1'b1;
                            r_fm_rd_addr <= w_next_base;
                        end
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (r_state != c_ST_IDLE);
    assign bus.done         = (r_state == c_ST_DONE);
    assign bus.out_valid    = (r_state == c_ST_WRITE);
    // operands are frozen in WRITE, so the core result is stable while stalled
    assign bus.out_data     = (r_state == c_ST_WRITE) ? bus.core_result : '0;
    assign bus.out_addr     = r_out_addr;
    assign bus.fm_rd_en     = r_fm_rd_en;
    assign bus.fm_rd_addr   = r_fm_rd_addr;
    assign bus.wt_rd_en     = r_wt_rd_en;
    assign bus.wt_rd_addr   = r_wt_rd_addr;
    assign bus.core_window  = r_window;
    assign bus.core_weights = r_weights;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_conv2d_seq_ctrl
// Description : Self-checking bench for conv2d_seq_ctrl with a 3x3 and a 4x4
//               instance, SRAM and core models, and a direct-convolution
//               reference computed from the map and kernel contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    conv2d_seq_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus3 ();
    conv2d_seq_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus4 ();

    conv2d_seq_ctrl #(.DATA_WIDTH(8), .IMG_W(3), .IMG_H(3), .ADDR_WIDTH(16))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));
    conv2d_seq_ctrl #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .ADDR_WIDTH(16))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [7:0] fm3 [0:8];
    logic [7:0] wt3 [0:8];
    logic [7:0] fm4 [0:15];
    logic [7:0] wt4 [0:8];

    // signed dot product wrapped to 16 bits, as the core produces it
    function automatic logic [15:0] core_sum(input logic [0:8][7:0] win, input logic [0:8][7:0] wts);
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'($signed(win[i])) * int'($signed(wts[i]));
        return s[15:0];
    endfunction

    // direct valid convolution of the 4x4 map for output index n
    function automatic logic [15:0] ref4(input int n);
        int s = 0;
        int ox = n % 2;
        int oy = n / 2;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                int a = $signed(fm4[(oy + ky) * 4 + ox + kx]);
                int b = $signed(wt4[ky * 3 + kx]);
                s += a * b;
            end
        return s[15:0];
    endfunction

    // SRAMs with one-cycle read latency and a core that registers its sum
    always @(posedge clk) begin
        if (bus3.fm_rd_en) bus3.fm_rd_data <= fm3[bus3.fm_rd_addr[3:0]];
        if (bus3.wt_rd_en) bus3.wt_rd_data <= wt3[bus3.wt_rd_addr[3:0]];
        bus3.core_result <= core_sum(bus3.core_window, bus3.core_weights);
        if (bus4.fm_rd_en) bus4.fm_rd_data <= fm4[bus4.fm_rd_addr[3:0]];
        if (bus4.wt_rd_en) bus4.wt_rd_data <= wt4[bus4.wt_rd_addr[3:0]];
        bus4.core_result <= core_sum(bus4.core_window, bus4.core_weights);
    end

    logic [15:0] q_data [$];
    int          q_addr [$];
    int          q_cyc  [$];
    int          fm_q   [$];
    int          done_cnt;
    int          done_cyc;

    // one 4x4 run from a start pulse in cycle 0; rmode 0=ready high,
    // 1=stall output sidx for slen cycles, 2=random ready
    task automatic run4(input int rmode, input int sidx, input int slen, input bit extra_start);
        int          stalled   = 0;
        bit          sent      = 1'b0;
        bit          prev_hold = 1'b0;
        logic [15:0] pd        = '0;
        logic [15:0] pa        = '0;
        q_data.delete(); q_addr.delete(); q_cyc.delete(); fm_q.delete();
        done_cnt = 0; done_cyc = -1;
        @(posedge clk); #1; bus4.start = 1'b1; bus4.out_ready = 1'b1;
        @(posedge clk); #1; bus4.start = 1'b0;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (prev_hold) begin
                tests_run++;
                if (bus4.out_valid !== 1'b1 || bus4.out_data !== pd || bus4.out_addr !== pa || bus4.fm_rd_en !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_hold cycle %0d: valid=%b data=%h addr=%0d fm_rd_en=%b, required valid=1 data=%h addr=%0d fm_rd_en=0",
                             c, bus4.out_valid, bus4.out_data, bus4.out_addr, bus4.fm_rd_en, pd, pa);
                end
            end
            prev_hold = bus4.out_valid && !bus4.out_ready;
            pd = bus4.out_data;
            pa = bus4.out_addr;
            if (bus4.out_valid && bus4.out_ready) begin
                q_data.push_back(bus4.out_data);
                q_addr.push_back(int'(bus4.out_addr));
                q_cyc.push_back(c);
            end
            if (bus4.fm_rd_en) fm_q.push_back(int'(bus4.fm_rd_addr));
            if (bus4.done) begin done_cnt++; done_cyc = c; end
            if (done_cnt > 0 && c >= done_cyc + 4) break;
            @(posedge clk); #1;
            case (rmode)
                1: if (bus4.out_valid && bus4.out_addr == 16'(sidx) && stalled < slen) begin
                       bus4.out_ready = 1'b0; stalled++;
                   end else bus4.out_ready = 1'b1;
                2: bus4.out_ready = ($urandom_range(0, 3) != 0);
                default: bus4.out_ready = 1'b1;
            endcase
            if (extra_start && !sent && bus4.fm_rd_en && q_data.size() == 1) begin
                bus4.start = 1'b1; sent = 1'b1;
            end else bus4.start = 1'b0;
        end
        bus4.out_ready = 1'b1;
        bus4.start     = 1'b0;
        tests_run++;
        if (done_cnt == 0) begin
            tests_failed++;
            $display("FAIL run4_timeout: done never seen, required a done pulse within 400 cycles");
        end
    endtask

    // compare every accepted 4x4 output against the reference, in order
    task automatic check4_outputs(input string name);
        tests_run++;
        if (q_data.size() != 4) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d outputs, required 4", name, q_data.size());
        end
        for (int n = 0; n < 4 && n < q_data.size(); n++) begin
            tests_run++;
            if (q_data[n] !== ref4(n) || q_addr[n] !== n) begin
                tests_failed++;
                $display("FAIL %s_out%0d: data=%h addr=%0d, required data=%h addr=%0d",
                         name, n, q_data[n], q_addr[n], ref4(n), n);
            end
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
        end
    endtask

    task automatic randomize4;
        for (int i = 0; i < 16; i++) fm4[i] = 8'($urandom);
        for (int i = 0; i < 9; i++)  wt4[i] = 8'($urandom);
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests_run++;
        if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.out_valid !== 1'b0 ||
            bus4.fm_rd_en !== 1'b0 || bus4.wt_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b done=%b valid=%b fm_en=%b wt_en=%b, required all 0",
                     bus4.busy, bus4.done, bus4.out_valid, bus4.fm_rd_en, bus4.wt_rd_en);
        end
        tests_run++;
        if (bus4.fm_rd_addr !== 16'd0 || bus4.wt_rd_addr !== 16'd0 || bus4.out_addr !== 16'd0 || bus4.out_data !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_addr: fm=%h wt=%h out_addr=%h out_data=%h, required all 0",
                     bus4.fm_rd_addr, bus4.wt_rd_addr, bus4.out_addr, bus4.out_data);
        end
        tests_run++;
        if (bus4.core_window !== '0 || bus4.core_weights !== '0 || bus3.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: window=%h weights=%h busy3=%b, required 0",
                     bus4.core_window, bus4.core_weights, bus3.busy);
        end
    endtask

    // single 3x3 run with ready held high; returns last output and timing
    task automatic run3(output logic [15:0] d, output int a, output int vcyc,
                        output int dcyc, output int bcyc, output int nout);
        d = 'x; a = -1; vcyc = -1; dcyc = -1; bcyc = -1; nout = 0;
        bus3.out_ready = 1'b1;
        @(posedge clk); #1; bus3.start = 1'b1;
        @(posedge clk); #1; bus3.start = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (bus3.out_valid && bus3.out_ready) begin
                nout++; d = bus3.out_data; a = int'(bus3.out_addr); vcyc = c;
            end
            if (bus3.done) dcyc = c;
            if (bcyc < 0 && dcyc >= 0 && !bus3.busy) bcyc = c;
        end
    endtask

    task automatic test_3x3_ones;
        logic [15:0] d; int a, vc, dc, bc, n;
        for (int i = 0; i < 9; i++) begin fm3[i] = 8'd1; wt3[i] = 8'd1; end
        run3(d, a, vc, dc, bc, n);
        tests_run++;
        if (n != 1 || d !== 16'd9 || a != 0) begin
            tests_failed++;
            $display("FAIL ones3_result: n=%0d data=%h addr=%0d, required n=1 data=0009 addr=0", n, d, a);
        end
        tests_run++;
        if (vc != 22 || dc != 23 || bc != 24) begin
            tests_failed++;
            $display("FAIL ones3_timing: valid@%0d done@%0d idle@%0d, required 22/23/24", vc, dc, bc);
        end
    endtask

    task automatic test_3x3_negative;
        logic [15:0] d; int a, vc, dc, bc, n;
        for (int i = 0; i < 9; i++) begin fm3[i] = 8'hFF; wt3[i] = 8'd2; end
        run3(d, a, vc, dc, bc, n);
        tests_run++;
        if (n != 1 || d !== 16'hFFEE) begin
            tests_failed++;
            $display("FAIL neg3_result: n=%0d data=%h, required n=1 data=ffee", n, d);
        end
    endtask

    task automatic test_pattern_4x4;
        int exp_data [4] = '{45, 54, 81, 90};
        int exp_fm   [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        for (int i = 0; i < 16; i++) fm4[i] = 8'(i);
        for (int i = 0; i < 9; i++)  wt4[i] = 8'd1;
        run4(0, 0, 0, 1'b0);
        check4_outputs("pattern");
        for (int n = 0; n < 4 && n < q_data.size(); n++) begin
            tests_run++;
            if (q_data[n] !== 16'(exp_data[n]) || q_cyc[n] != 22 + 12 * n) begin
                tests_failed++;
                $display("FAIL pattern_out%0d: data=%0d cycle=%0d, required data=%0d cycle=%0d",
                         n, q_data[n], q_cyc[n], exp_data[n], 22 + 12 * n);
            end
        end
        tests_run++;
        if (done_cyc != 59) begin
            tests_failed++;
            $display("FAIL pattern_done_cycle: got %0d, required 59", done_cyc);
        end
        tests_run++;
        if (fm_q.size() != 36) begin
            tests_failed++;
            $display("FAIL pattern_read_count: got %0d reads, required 36", fm_q.size());
        end
        for (int k = 0; k < 9 && 9 + k < fm_q.size(); k++) begin
            tests_run++;
            if (fm_q[9 + k] != exp_fm[k]) begin
                tests_failed++;
                $display("FAIL pattern_fm_addr%0d: got %0d, required %0d", k, fm_q[9 + k], exp_fm[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 16; i++) fm4[i] = 8'(i);
        for (int i = 0; i < 9; i++)  wt4[i] = 8'd1;
        run4(1, 1, 5, 1'b0);
        check4_outputs("stall");
        tests_run++;
        if (done_cyc != 64 || q_cyc.size() < 2 || q_cyc[1] != 39) begin
            tests_failed++;
            $display("FAIL stall_timing: done@%0d out1@%0d, required done@64 out1@39",
                     done_cyc, (q_cyc.size() > 1) ? q_cyc[1] : -1);
        end
    endtask

    task automatic test_start_during_fetch;
        randomize4();
        run4(0, 0, 0, 1'b1);
        check4_outputs("restart");
        tests_run++;
        if (bus4.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_idle: busy=%b after done, required 0", bus4.busy);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 3; it++) begin
            randomize4();
            run4(2, 0, 0, 1'b0);
            check4_outputs("random");
        end
    endtask

    task automatic test_reset_midrun;
        bit hit = 1'b0;
        randomize4();
        @(posedge clk); #1; bus4.start = 1'b1;
        @(posedge clk); #1; bus4.start = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk); #1;
            if (bus4.fm_rd_en) hit = 1'b1;
        end
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL midrun_fetch: no FETCH read within 40 cycles, required one");
        end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus4.busy !== 1'b0 || bus4.out_valid !== 1'b0 || bus4.fm_rd_en !== 1'b0 ||
            bus4.wt_rd_en !== 1'b0 || bus4.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_abort: busy=%b valid=%b fm_en=%b wt_en=%b done=%b, required all 0",
                     bus4.busy, bus4.out_valid, bus4.fm_rd_en, bus4.wt_rd_en, bus4.done);
        end
        randomize4();
        run4(0, 0, 0, 1'b0);
        check4_outputs("after_reset");
        tests_run++;
        if (q_cyc.size() == 0 || q_cyc[0] != 22) begin
            tests_failed++;
            $display("FAIL after_reset_latency: first output@%0d, required 22",
                     (q_cyc.size() > 0) ? q_cyc[0] : -1);
        end
    endtask

    initial begin
        bus3.start = 1'b0; bus3.out_ready = 1'b1;
        bus4.start = 1'b0; bus4.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1; rst = 1'b0;
        test_3x3_ones();
        test_3x3_negative();
        test_pattern_4x4();
        test_backpressure();
        test_start_during_fetch();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
